// File: rtl/dmem_access_unit.sv
// ---------------------------------------------------------------------------
// dmem_access_unit
//   MEM-stage data-memory interface between the pipeline datapath and a
//   variable-latency req/ack data bus. It places store data into byte lanes
//   and generates byte enables, runs the bus handshake, and right-justifies
//   load data. It stalls the pipeline while a transaction is outstanding,
//   rejects misaligned accesses, and aborts a transaction if ack never comes.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   i_memRead/Write     load / store request (store wins if both are set)
//   i_memSize           00 byte, 01 half, 10/11 word
//   i_addr, i_wdata     byte address, right-justified store data
//   o_stall             hold IF..MEM stages this cycle
//   o_readData          right-justified load data, zero-extended
//   o_misaligned        1-cycle pulse: access rejected
//   o_busError          1-cycle pulse in DONE after an ack timeout
//   o_busReq/We/Addr/Wdata/Be   bus request side, driven only in BUSY
//   i_busAck, i_busRdata        bus completion and read word
// ---------------------------------------------------------------------------
module dmem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_memRead,
    input  logic        i_memWrite,
    input  logic [1:0]  i_memSize,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic [31:0] o_readData,
    output logic        o_misaligned,
    output logic        o_busError,
    output logic        o_busReq,
    output logic        o_busWe,
    output logic [31:0] o_busAddr,
    output logic [31:0] o_busWdata,
    output logic [3:0]  o_busBe,
    input  logic        i_busAck,
    input  logic [31:0] i_busRdata
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic              err;
    logic [31:0]       rdata;
    logic [31:0]       addr_lat;
    logic [31:0]       wdata_lat;
    logic [3:0]        be_lat;
    logic              we_lat;
    logic [1:0]        size_lat;
    logic [1:0]        off_lat;

    logic              access;
    logic              aligned;
    logic              latch_en;
    logic              capture_en;
    logic              timeout;

    // Byte enables for a given size and byte offset; reads always use all lanes.
    function automatic logic [3:0] calc_be(input logic we, input logic [1:0] size,
                                           input logic [1:0] off);
        logic [3:0] be;
        if (!we) begin
            be = 4'hF;
        end else begin
            case (size)
                2'b00:   be = 4'b0001 << off;
                2'b01:   be = 4'b0011 << off;
                default: be = 4'hF;
            endcase
        end
        return be;
    endfunction

    // Shift the read word down to bit 0 and keep only the accessed bytes.
    function automatic logic [31:0] justify(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] off);
        logic [31:0] shifted;
        shifted = word >> {off, 3'b000};
        case (size)
            2'b00:   return shifted & 32'h0000_00FF;
            2'b01:   return shifted & 32'h0000_FFFF;
            default: return shifted;
        endcase
    endfunction

    // Alignment check: half needs an even address, word needs a 4-byte boundary.
    always_comb begin
        access = i_memRead | i_memWrite;
        case (i_memSize)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~i_addr[0];
            default: aligned = (i_addr[1:0] == 2'b00);
        endcase
    end

    // Next-state logic and outputs; bus signals come only from latched values.
    always_comb begin
        state_next   = state;
        o_stall      = 1'b0;
        o_misaligned = 1'b0;
        o_busError   = 1'b0;
        o_busReq     = 1'b0;
        o_busWe      = 1'b0;
        o_busAddr    = 32'h0;
        o_busWdata   = 32'h0;
        o_busBe      = 4'h0;
        latch_en     = 1'b0;
        capture_en   = 1'b0;
        timeout      = 1'b0;
        case (state)
            IDLE: begin
                if (access && aligned) begin
                    o_stall    = 1'b1;
                    latch_en   = 1'b1;
                    state_next = BUSY;
                end else if (access) begin
                    o_misaligned = 1'b1;
                end else begin
                    o_stall = 1'b0;
                end
            end
            BUSY: begin
                o_stall    = 1'b1;
                o_busReq   = 1'b1;
                o_busWe    = we_lat;
                o_busAddr  = addr_lat;
                o_busWdata = wdata_lat;
                o_busBe    = be_lat;
                // An ack in the final allowed cycle still completes normally.
                if (i_busAck) begin
                    capture_en = 1'b1;
                    state_next = DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout    = 1'b1;
                    state_next = DONE;
                end else begin
                    state_next = BUSY;
                end
            end
            DONE: begin
                o_busError = err;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read data is visible continuously; the datapath only samples it in DONE.
    assign o_readData = rdata;

    // State, wait counter, error flag, captured data and latched request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            err       <= 1'b0;
            rdata     <= 32'h0;
            addr_lat  <= 32'h0;
            wdata_lat <= 32'h0;
            be_lat    <= 4'h0;
            we_lat    <= 1'b0;
            size_lat  <= 2'b00;
            off_lat   <= 2'b00;
        end else begin
            state <= state_next;
            if (latch_en) begin
                addr_lat  <= {i_addr[31:2], 2'b00};
                wdata_lat <= i_wdata << {i_addr[1:0], 3'b000};
                be_lat    <= calc_be(i_memWrite, i_memSize, i_addr[1:0]);
                we_lat    <= i_memWrite;
                size_lat  <= i_memSize;
                off_lat   <= i_addr[1:0];
            end else begin
                addr_lat <= addr_lat;
            end
            if (state == BUSY) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
            if (capture_en) begin
                // Stores return zero so the datapath never sees stale load data.
                rdata <= we_lat ? 32'h0 : justify(i_busRdata, size_lat, off_lat);
                err   <= 1'b0;
            end else if (timeout) begin
                rdata <= 32'h0;
                err   <= 1'b1;
            end else if (state == DONE) begin
                err <= 1'b0;
            end else begin
                err <= err;
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_memRead, i_memWrite;
    logic [1:0]  i_memSize;
    logic [31:0] i_addr, i_wdata;
    logic        o_stall;
    logic [31:0] o_readData;
    logic        o_misaligned, o_busError, o_busReq, o_busWe;
    logic [31:0] o_busAddr, o_busWdata;
    logic [3:0]  o_busBe;
    logic        i_busAck;
    logic [31:0] i_busRdata;

    int checks = 0;
    int failures = 0;

    dmem_access_unit dut (
        .clk(clk), .reset(reset),
        .i_memRead(i_memRead), .i_memWrite(i_memWrite), .i_memSize(i_memSize),
        .i_addr(i_addr), .i_wdata(i_wdata),
        .o_stall(o_stall), .o_readData(o_readData), .o_misaligned(o_misaligned),
        .o_busError(o_busError), .o_busReq(o_busReq), .o_busWe(o_busWe),
        .o_busAddr(o_busAddr), .o_busWdata(o_busWdata), .o_busBe(o_busBe),
        .i_busAck(i_busAck), .i_busRdata(i_busRdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
        i_memRead  = rd;
        i_memWrite = wr;
        i_memSize  = sz;
        i_addr     = a;
        i_wdata    = wd;
    endtask

    task automatic idle_inputs();
        req(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        i_busAck = 1'b0;
    endtask

    int n;

    initial begin
        reset = 1'b1;
        idle_inputs();
        i_busRdata = 32'h0;
        step();
        step();
        @(negedge clk);
        check("rst_stall", {31'h0, o_stall}, 32'h0);
        check("rst_req", {31'h0, o_busReq}, 32'h0);
        check("rst_rdata", o_readData, 32'h0);
        check("rst_be", {28'h0, o_busBe}, 32'h0);
        step();
        reset = 1'b0;

        // 1. LW 0x100, ack in first BUSY cycle
        req(1'b1, 1'b0, 2'b10, 32'h100, 32'h0);
        @(negedge clk);
        check("lw_idle_stall", {31'h0, o_stall}, 32'h1);
        check("lw_idle_req", {31'h0, o_busReq}, 32'h0);
        step();
        i_busAck = 1'b1;
        i_busRdata = 32'hDEADBEEF;
        @(negedge clk);
        check("lw_busy_stall", {31'h0, o_stall}, 32'h1);
        check("lw_be", {28'h0, o_busBe}, 32'hF);
        check("lw_addr", o_busAddr, 32'h100);
        check("lw_we", {31'h0, o_busWe}, 32'h0);
        step();
        i_busAck = 1'b0;
        @(negedge clk);
        check("lw_done_stall", {31'h0, o_stall}, 32'h0);
        check("lw_done_req", {31'h0, o_busReq}, 32'h0);
        check("lw_data", o_readData, 32'hDEADBEEF);
        check("lw_err", {31'h0, o_busError}, 32'h0);
        step();
        idle_inputs();

        // 2. SB 0x103
        req(1'b0, 1'b1, 2'b00, 32'h103, 32'h0000_00A5);
        step();
        i_busAck = 1'b1;
        @(negedge clk);
        check("sb_addr", o_busAddr, 32'h100);
        check("sb_be", {28'h0, o_busBe}, 32'h8);
        check("sb_wdata", o_busWdata, 32'hA500_0000);
        check("sb_we", {31'h0, o_busWe}, 32'h1);
        step();
        i_busAck = 1'b0;
        @(negedge clk);
        check("sb_data", o_readData, 32'h0);
        step();
        idle_inputs();

        // 3. LH 0x102, then misaligned LH 0x101
        req(1'b1, 1'b0, 2'b01, 32'h102, 32'h0);
        step();
        i_busAck = 1'b1;
        i_busRdata = 32'h8123_4567;
        step();
        i_busAck = 1'b0;
        @(negedge clk);
        check("lh_data", o_readData, 32'h0000_8123);
        step();
        req(1'b1, 1'b0, 2'b01, 32'h101, 32'h0);
        @(negedge clk);
        check("lh_mis", {31'h0, o_misaligned}, 32'h1);
        check("lh_mis_stall", {31'h0, o_stall}, 32'h0);
        check("lh_mis_req", {31'h0, o_busReq}, 32'h0);
        step();
        idle_inputs();
        @(negedge clk);
        check("lh_mis_after_req", {31'h0, o_busReq}, 32'h0);
        check("lh_mis_after_pulse", {31'h0, o_misaligned}, 32'h0);

        // 4. LB 0x200, ack withheld -> timeout
        step();
        req(1'b1, 1'b0, 2'b00, 32'h200, 32'h0);
        step();
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!o_busReq) break;
            n++;
            step();
        end
        check("to_req_cycles", n, 32'd255);
        check("to_err", {31'h0, o_busError}, 32'h1);
        check("to_data", o_readData, 32'h0);
        check("to_stall", {31'h0, o_stall}, 32'h0);
        step();
        idle_inputs();
        @(negedge clk);
        check("to_err_clear", {31'h0, o_busError}, 32'h0);

        // 5. SW 0x300 stalled 4 cycles with changing inputs
        step();
        req(1'b0, 1'b1, 2'b10, 32'h300, 32'h1122_3344);
        step();
        i_addr  = 32'h400;
        i_wdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 4; k++) begin
            i_busAck = (k == 3);
            @(negedge clk);
            check("sw_addr", o_busAddr, 32'h300);
            check("sw_wdata", o_busWdata, 32'h1122_3344);
            check("sw_be", {28'h0, o_busBe}, 32'hF);
            step();
        end
        i_busAck = 1'b0;
        @(negedge clk);
        check("sw_done_stall", {31'h0, o_stall}, 32'h0);
        step();
        idle_inputs();

        // 6. Reset mid-BUSY, late ack ignored
        req(1'b1, 1'b0, 2'b10, 32'h500, 32'h0);
        step();
        @(negedge clk);
        check("rb_req", {31'h0, o_busReq}, 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle_inputs();
        i_busAck = 1'b1;
        i_busRdata = 32'h5555_5555;
        @(negedge clk);
        check("rb_req_low", {31'h0, o_busReq}, 32'h0);
        check("rb_stall", {31'h0, o_stall}, 32'h0);
        step();
        i_busAck = 1'b0;
        @(negedge clk);
        check("rb_data", o_readData, 32'h0);
        check("rb_req_low2", {31'h0, o_busReq}, 32'h0);

        // 7. Ack in the final timeout cycle wins; LB at offset 1
        step();
        req(1'b1, 1'b0, 2'b00, 32'h201, 32'h0);
        step();
        for (int i = 0; i < 254; i++) step();
        i_busAck = 1'b1;
        i_busRdata = 32'h0000_AB00;
        @(negedge clk);
        check("late_req", {31'h0, o_busReq}, 32'h1);
        step();
        i_busAck = 1'b0;
        @(negedge clk);
        check("late_err", {31'h0, o_busError}, 32'h0);
        check("late_data", o_readData, 32'h0000_00AB);
        step();
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
